// File: rtl/adder_tree_avg_pipe_pkg.sv
// Shared types and width helpers for the pipelined adder-tree averager.
package adder_tree_pkg;

  typedef enum logic {
    OVF_SAT  = 1'b0,
    OVF_ZERO = 1'b1
  } ovf_mode_e;

  function automatic int unsigned log2n(input int unsigned n_ch);
    return $clog2(n_ch);
  endfunction

  function automatic int unsigned w_sum(input int unsigned w_in, input int unsigned n_ch);
    return w_in + log2n(n_ch);
  endfunction

  function automatic int unsigned w_sh(input int unsigned w_in, input int unsigned n_ch);
    return $clog2(w_sum(w_in, n_ch) + 1);
  endfunction

endpackage

// File: rtl/adder_tree_avg_pipe_if.sv
// Sample-in / result-out bus of the adder-tree averager.
interface adder_tree_avg_pipe_if
  import adder_tree_pkg::*;
#(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned W_IN  = 8,
  parameter int unsigned W_OUT = 8
);
  localparam int unsigned W_SH = w_sh(W_IN, N_CH);

  logic                   in_valid;
  logic [N_CH*W_IN-1:0]   in_data;
  logic [W_SH-1:0]        shift;
  ovf_mode_e              ovf_mode;
  logic                   clr;
  logic                   out_valid;
  logic [W_OUT-1:0]       out_data;
  logic                   ovf;

  modport master (
    output in_valid, in_data, shift, ovf_mode, clr,
    input  out_valid, out_data, ovf
  );

  modport slave (
    input  in_valid, in_data, shift, ovf_mode, clr,
    output out_valid, out_data, ovf
  );

endinterface

// File: rtl/adder_tree_avg_pipe_tree_add_level.sv
// One registered level of the adder tree: pairwise zero-extended sums plus
// valid and sideband carried alongside.
module tree_add_level #(
  parameter int unsigned N_IN = 2,
  parameter int unsigned W    = 8,
  parameter int unsigned W_SB = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          in_valid,
  input  logic [N_IN*W-1:0]             in_data,
  input  logic [W_SB-1:0]               in_sb,
  output logic                          out_valid,
  output logic [(N_IN/2)*(W+1)-1:0]     out_data,
  output logic [W_SB-1:0]               out_sb
);

  localparam int unsigned N_OUT = N_IN / 2;
  localparam int unsigned W_O   = W + 1;

  logic [N_OUT*W_O-1:0] sum_c;
  logic                 load;

  assign load = in_valid & ~clr;

  // Full-precision pair sums; one extra bit per level, never truncated.
  always_comb begin
    sum_c = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      sum_c[k*W_O +: W_O] = W_O'(in_data[2*k*W +: W]) + W_O'(in_data[(2*k+1)*W +: W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sb    <= '0;
    end else begin
      out_valid <= load;
      if (load) begin
        out_data <= sum_c;
        out_sb   <= in_sb;
      end
    end
  end

endmodule

// File: rtl/adder_tree_avg_pipe.sv
// Fully pipelined N_CH-channel adder tree with runtime right-shift scaling and
// saturate / force-zero overflow handling; latency LOG2N+2, one sample per cycle.
module adder_tree_avg_pipe
  import adder_tree_pkg::*;
#(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned W_IN  = 8,
  parameter int unsigned W_OUT = 8
) (
  input  logic                  CK,
  input  logic                  RSTB,
  adder_tree_avg_pipe_if.slave  bus
);

  localparam int unsigned LOG2N = log2n(N_CH);
  localparam int unsigned W_SUM = w_sum(W_IN, N_CH);
  localparam int unsigned W_SH  = w_sh(W_IN, N_CH);
  localparam int unsigned W_SB  = W_SH + 1;
  localparam int unsigned W_EXT = (W_SUM > W_OUT) ? W_SUM : W_OUT;

  // Input register stage; sideband is {shift, ovf_mode}.
  logic                  s0_valid;
  logic [N_CH*W_IN-1:0]  s0_data;
  logic [W_SB-1:0]       s0_sb;
  logic                  s0_load;

  assign s0_load = bus.in_valid & ~bus.clr;

  always_ff @(posedge CK or negedge RSTB) begin
    if (!RSTB) begin
      s0_valid <= 1'b0;
      s0_data  <= '0;
      s0_sb    <= '0;
    end else begin
      s0_valid <= s0_load;
      if (s0_load) begin
        s0_data <= bus.in_data;
        s0_sb   <= {bus.shift, bus.ovf_mode};
      end
    end
  end

  // Tree levels: level j consumes N_CH>>j operands of width W_IN+j.
  for (genvar j = 0; j < LOG2N; j++) begin : g_lvl
    localparam int unsigned NI = N_CH >> j;
    localparam int unsigned WI = W_IN + j;

    logic [NI*WI-1:0]           lvl_in;
    logic                       lvl_in_valid;
    logic [W_SB-1:0]            lvl_in_sb;
    logic [(NI/2)*(WI+1)-1:0]   lvl_out;
    logic                       lvl_out_valid;
    logic [W_SB-1:0]            lvl_out_sb;

    if (j == 0) begin : g_first
      assign lvl_in       = s0_data;
      assign lvl_in_valid = s0_valid;
      assign lvl_in_sb    = s0_sb;
    end else begin : g_next
      assign lvl_in       = g_lvl[j-1].lvl_out;
      assign lvl_in_valid = g_lvl[j-1].lvl_out_valid;
      assign lvl_in_sb    = g_lvl[j-1].lvl_out_sb;
    end

    tree_add_level #(
      .N_IN (NI),
      .W    (WI),
      .W_SB (W_SB)
    ) u_lvl (
      .clk       (CK),
      .rst_n     (RSTB),
      .clr       (bus.clr),
      .in_valid  (lvl_in_valid),
      .in_data   (lvl_in),
      .in_sb     (lvl_in_sb),
      .out_valid (lvl_out_valid),
      .out_data  (lvl_out),
      .out_sb    (lvl_out_sb)
    );
  end

  logic [W_SUM-1:0]  fin_sum;
  logic              fin_valid;
  logic [W_SH-1:0]   fin_shift;
  ovf_mode_e         fin_mode;
  logic [W_SH-1:0]   sh_eff;
  logic [W_EXT-1:0]  scaled;
  logic              ovf_c;
  logic [W_OUT-1:0]  data_c;
  logic              fin_load;

  assign fin_sum   = g_lvl[LOG2N-1].lvl_out;
  assign fin_valid = g_lvl[LOG2N-1].lvl_out_valid;
  assign fin_shift = g_lvl[LOG2N-1].lvl_out_sb[W_SB-1:1];
  assign fin_mode  = ovf_mode_e'(g_lvl[LOG2N-1].lvl_out_sb[0]);
  assign fin_load  = fin_valid & ~bus.clr;

  // Scale and overflow policy; shifts beyond W_SUM clamp so the result is 0.
  always_comb begin
    sh_eff = (fin_shift > W_SH'(W_SUM)) ? W_SH'(W_SUM) : fin_shift;
    scaled = W_EXT'(fin_sum >> sh_eff);
    ovf_c  = |(scaled >> W_OUT);
    data_c = scaled[W_OUT-1:0];
    if (ovf_c) begin
      data_c = (fin_mode == OVF_SAT) ? '1 : '0;
    end
  end

  // Output register; data and ovf hold across bubbles.
  always_ff @(posedge CK or negedge RSTB) begin
    if (!RSTB) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.ovf       <= 1'b0;
    end else begin
      bus.out_valid <= fin_load;
      if (fin_load) begin
        bus.out_data <= data_c;
        bus.ovf      <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_avg_pipe.sv
// Randomized and directed bench for adder_tree_avg_pipe against a
// per-sample arithmetic model with a latency-countdown scoreboard.
module tb_adder_tree_avg_pipe;
  import adder_tree_pkg::*;

  localparam int unsigned N_CH   = 8;
  localparam int unsigned W_IN   = 8;
  localparam int unsigned W_OUT  = 8;
  localparam int unsigned W_SUM  = 11;
  localparam int unsigned W_SH   = 4;
  localparam int unsigned W_DATA = N_CH * W_IN;
  localparam int          LAT    = 5;

  typedef struct {
    int cnt;
    int data;
    int ovf;
  } exp_t;

  logic clk;
  logic rst_n;

  adder_tree_avg_pipe_if #(.N_CH(N_CH), .W_IN(W_IN), .W_OUT(W_OUT)) bus ();

  adder_tree_avg_pipe #(.N_CH(N_CH), .W_IN(W_IN), .W_OUT(W_OUT)) dut (
    .CK   (clk),
    .RSTB (rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;
  exp_t q[$];
  int   exp_v    = 0;
  int   exp_data = 0;
  int   exp_ovf  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, expv, $time);
    end
  endtask

  // Arithmetic definition of one result, independent of pipeline structure.
  function automatic void ref_calc(input logic [W_DATA-1:0] d, input int sh, input int mode,
                                   output int data, output int o);
    longint sum = 0;
    longint scaled;
    longint max_out = (longint'(1) << W_OUT) - 1;
    for (int k = 0; k < int'(N_CH); k++) sum += longint'(d[k*W_IN +: W_IN]);
    if (sh > int'(W_SUM)) sh = int'(W_SUM);
    scaled = sum >> sh;
    if (scaled > max_out) begin
      o    = 1;
      data = (mode != 0) ? 0 : int'(max_out);
    end else begin
      o    = 0;
      data = int'(scaled);
    end
  endfunction

  task automatic model_edge();
    exp_t e;
    if (!rst_n) return;
    if (bus.clr) begin
      q.delete();
      exp_v = 0;
      return;
    end
    foreach (q[i]) q[i].cnt--;
    exp_v = 0;
    if (q.size() > 0 && q[0].cnt == 0) begin
      e        = q.pop_front();
      exp_v    = 1;
      exp_data = e.data;
      exp_ovf  = e.ovf;
    end
    if (bus.in_valid) begin
      ref_calc(bus.in_data, int'(bus.shift), int'(bus.ovf_mode), e.data, e.ovf);
      e.cnt = LAT - 1;
      q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (bus.out_valid) n_out++;
    check("out_valid", bus.out_valid, exp_v);
    check("out_data", bus.out_data, exp_data);
    check("ovf", bus.ovf, exp_ovf);
  endtask

  task automatic drive(input bit v, input logic [W_DATA-1:0] d, input int sh, input int mode, input bit c);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.shift    = W_SH'(sh);
    bus.ovf_mode = (mode != 0) ? OVF_ZERO : OVF_SAT;
    bus.clr      = c;
  endtask

  function automatic logic [W_DATA-1:0] all_ch(input int v);
    logic [W_DATA-1:0] r;
    for (int k = 0; k < int'(N_CH); k++) r[k*W_IN +: W_IN] = W_IN'(v);
    return r;
  endfunction

  function automatic logic [W_DATA-1:0] rand_ch(input int lo);
    logic [W_DATA-1:0] r;
    for (int k = 0; k < int'(N_CH); k++) r[k*W_IN +: W_IN] = W_IN'($urandom_range(lo, 255));
    return r;
  endfunction

  // Single isolated sample with literal expectations and a latency count.
  task automatic send_one(input int v, input int sh, input int mode, input int exp_d, input int exp_o);
    int lat;
    drive(1'b1, all_ch(v), sh, mode, 1'b0);
    step();
    drive(1'b0, all_ch(v), sh, mode, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 12) begin
      step();
      lat++;
    end
    if (bus.out_valid) begin
      check("latency", 64'(lat), 64'(LAT));
      check("dir_data", bus.out_data, 64'(exp_d));
      check("dir_ovf", bus.ovf, 64'(exp_o));
    end else begin
      check("out_timeout", 64'(0), 64'(1));
    end
  endtask

  initial begin
    logic [W_DATA-1:0] stream_d;
    int base;

    rst_n = 1'b0;
    drive(1'b0, '0, 0, 0, 1'b0);
    #1;
    check("rst_valid", bus.out_valid, 64'(0));
    check("rst_data", bus.out_data, 64'(0));
    check("rst_ovf", bus.ovf, 64'(0));
    step();
    step();
    rst_n = 1'b1;
    step();

    send_one(100, 2, 0, 200, 0);
    send_one(255, 2, 0, 255, 1);
    send_one(255, 2, 1, 0, 1);
    send_one(255, 3, 0, 255, 0);
    send_one(255, 12, 0, 0, 0);
    send_one(255, 15, 1, 0, 0);

    // Back-to-back stream with alternating sideband and a single bubble.
    for (int k = 0; k < int'(N_CH); k++) stream_d[k*W_IN +: W_IN] = W_IN'(k * 10);
    base = n_out;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, stream_d, (i % 2 != 0) ? 3 : 2, i % 2, 1'b0);
      step();
      if (i == 2) begin
        drive(1'b0, stream_d, 0, 0, 1'b0);
        step();
      end
    end
    drive(1'b0, stream_d, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) step();
    check("stream_count", 64'(n_out - base), 64'(6));

    // Asynchronous reset with three samples in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rand_ch(200), 0, i % 2, 1'b0);
      step();
    end
    drive(1'b0, '0, 0, 0, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    exp_v = 0; exp_data = 0; exp_ovf = 0;
    check("midrst_valid", bus.out_valid, 64'(0));
    check("midrst_data", bus.out_data, 64'(0));
    check("midrst_ovf", bus.ovf, 64'(0));
    step();
    rst_n = 1'b1;
    base = n_out;
    for (int i = 0; i < 8; i++) step();
    check("post_rst_quiet", 64'(n_out - base), 64'(0));
    send_one(100, 2, 0, 200, 0);

    // clr with a sample arriving together with two in flight.
    base = n_out;
    drive(1'b1, rand_ch(0), 1, 0, 1'b0); step();
    drive(1'b1, rand_ch(0), 2, 1, 1'b0); step();
    drive(1'b1, rand_ch(0), 0, 0, 1'b1); step();
    drive(1'b1, rand_ch(0), 3, 0, 1'b0); step();
    drive(1'b0, '0, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) step();
    check("clr_count", 64'(n_out - base), 64'(1));

    // Random traffic with occasional clears and overflow-prone data.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 1) != 0) ? rand_ch(0) : rand_ch(200),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
            $urandom_range(0, 24) == 0);
      step();
    end
    drive(1'b0, '0, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
